// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit positions, reset defaults and FSM state types for uart_core.
// Optional feature macro: UART_PARITY_EN (adds the PARITY state and CTRL[3:2]/STATUS[4]).
package uart_pkg;

    localparam logic [15:0] DIV_RST_DEFAULT = 16'd868;
    localparam logic [15:0] DIV_MIN_DEFAULT = 16'd4;

    // Word offsets, compared against addr[4:2]
    localparam logic [2:0] OFF_TXDATA = 3'd0;
    localparam logic [2:0] OFF_RXDATA = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_DIV    = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    localparam int unsigned ST_TX_BUSY    = 0;
    localparam int unsigned ST_RX_VALID   = 1;
    localparam int unsigned ST_RX_OVERRUN = 2;
    localparam int unsigned ST_FRAME_ERR  = 3;
    localparam int unsigned ST_PAR_ERR    = 4;

    localparam int unsigned CT_TX_EN   = 0;
    localparam int unsigned CT_RX_EN   = 1;
    localparam int unsigned CT_PAR_EN  = 2;
    localparam int unsigned CT_PAR_ODD = 3;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
`else
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
`endif

endpackage

// File: rtl/uart_if.sv
// uart_if: register bus between the AHB wrapper (master) and uart_core (slave).
interface uart_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, output we, output wd, input rd);
    modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: rx synchronizer, start detection, bit sampling and shift register.
// Optional feature macro: UART_PARITY_EN (parity sampling and par_err output).
module uart_rx_fsm
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic        rx_en,
    input  logic [15:0] div,
`ifdef UART_PARITY_EN
    input  logic        par_en,
    input  logic        par_odd,
    output logic        par_err,
`endif
    output logic [7:0]  data,
    output logic        done,
    output logic        stop_err
);

    logic        sync1_q, sync2_q, prev_q;
    rx_state_e   state_q;
    logic [15:0] cnt_q, div_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        tick;
`ifdef UART_PARITY_EN
    logic        par_en_q, par_odd_q, par_bad_q;
    assign par_err = par_bad_q;
`endif

    // Sample half a bit into the start bit, then one full bit period per later bit.
    always_comb begin
        if (state_q == RxStart) begin
            tick = (cnt_q == (div_q >> 1) - 16'd1);
        end else begin
            tick = (cnt_q == div_q - 16'd1);
        end
    end

    assign data     = shift_q;
    assign done     = rx_en && (state_q == RxStop) && tick;
    assign stop_err = ~sync2_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receive FSM; dropping rx_en abandons any frame in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else if (!rx_en) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
        end else begin
            cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
            unique case (state_q)
                RxIdle: begin
                    cnt_q <= '0;
                    if (prev_q && !sync2_q) begin
                        state_q <= RxStart;
                        div_q   <= div;
`ifdef UART_PARITY_EN
                        par_en_q  <= par_en;
                        par_odd_q <= par_odd;
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                RxStart: begin
                    bit_q <= '0;
                    if (tick) state_q <= sync2_q ? RxIdle : RxData;
                end
                RxData: begin
                    if (tick) begin
                        shift_q[bit_q] <= sync2_q;
                        bit_q          <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= par_en_q ? RxParity : RxStop;
`else
                            state_q <= RxStop;
`endif
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RxParity: begin
                    if (tick) begin
                        par_bad_q <= sync2_q ^ (^shift_q) ^ par_odd_q;
                        state_q   <= RxStop;
                    end
                end
`endif
                RxStop: begin
                    if (tick) state_q <= RxIdle;
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART with register file, TX FSM and sticky status flags.
// Optional feature macro: UART_PARITY_EN (CTRL par_en/par_odd, STATUS par_err, 11-bit frames).
module uart_core
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RST = DIV_RST_DEFAULT,
    parameter logic [15:0] DIV_MIN = DIV_MIN_DEFAULT
) (
    input  logic   clk,
    input  logic   resetn,
    uart_if.slave  bus,
    output logic   uart_tx,
    input  logic   uart_rx
);

    logic [2:0]  sel;
    logic        wr_tx, wr_stat, wr_div, wr_ctrl, tx_start, tx_busy, tx_tick;
    logic [15:0] div_q, tx_cnt_q, tx_div_q;
    logic        tx_en_q, rx_en_q, rx_valid_q, rx_overrun_q, frame_err_q, uart_tx_q;
    logic [7:0]  rxdata_q, tx_byte_q, rx_data;
    logic [2:0]  tx_bit_q;
    logic        rx_done, rx_stop_err;
    tx_state_e   tx_state_q;
    logic [31:0] rd_data;
    logic        unused_bits;
`ifdef UART_PARITY_EN
    logic        par_en_q, par_odd_q, par_err_q, tx_par_en_q, tx_par_odd_q, rx_par_err;
`endif

    assign sel      = bus.addr[4:2];
    assign wr_tx    = bus.we && (sel == OFF_TXDATA);
    assign wr_stat  = bus.we && (sel == OFF_STATUS);
    assign wr_div   = bus.we && (sel == OFF_DIV);
    assign wr_ctrl  = bus.we && (sel == OFF_CTRL);
    assign tx_busy  = (tx_state_q != TxIdle);
    assign tx_start = wr_tx && tx_en_q && !tx_busy;
    assign tx_tick  = (tx_cnt_q == tx_div_q - 16'd1);
    assign uart_tx  = uart_tx_q;
    assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wd[31:16]};

    uart_rx_fsm u_rx (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (uart_rx),
        .rx_en    (rx_en_q),
        .div      (div_q),
`ifdef UART_PARITY_EN
        .par_en   (par_en_q),
        .par_odd  (par_odd_q),
        .par_err  (rx_par_err),
`endif
        .data     (rx_data),
        .done     (rx_done),
        .stop_err (rx_stop_err)
    );

    // Config registers and receive holding register; DIV writes clamp at DIV_MIN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q    <= DIV_RST;
            tx_en_q  <= 1'b0;
            rx_en_q  <= 1'b0;
            rxdata_q <= '0;
`ifdef UART_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
`endif
        end else begin
            if (wr_div) div_q <= (bus.wd[15:0] < DIV_MIN) ? DIV_MIN : bus.wd[15:0];
            if (wr_ctrl) begin
                tx_en_q <= bus.wd[CT_TX_EN];
                rx_en_q <= bus.wd[CT_RX_EN];
`ifdef UART_PARITY_EN
                par_en_q  <= bus.wd[CT_PAR_EN];
                par_odd_q <= bus.wd[CT_PAR_ODD];
`endif
            end
            if (rx_done) rxdata_q <= rx_data;
        end
    end

    // Sticky flags: a hardware set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            rx_valid_q   <= (rx_valid_q & ~(wr_stat & bus.wd[ST_RX_VALID])) | rx_done;
            rx_overrun_q <= (rx_overrun_q & ~(wr_stat & bus.wd[ST_RX_OVERRUN]))
                          | (rx_done & rx_valid_q);
            frame_err_q  <= (frame_err_q & ~(wr_stat & bus.wd[ST_FRAME_ERR]))
                          | (rx_done & rx_stop_err);
`ifdef UART_PARITY_EN
            par_err_q    <= (par_err_q & ~(wr_stat & bus.wd[ST_PAR_ERR]))
                          | (rx_done & rx_par_err);
`endif
        end
    end

    // Transmit FSM; divisor and parity mode are frozen for the whole frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_byte_q  <= '0;
            tx_bit_q   <= '0;
            uart_tx_q  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_en_q  <= 1'b0;
            tx_par_odd_q <= 1'b0;
`endif
        end else begin
            tx_cnt_q <= tx_tick ? 16'd0 : tx_cnt_q + 16'd1;
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_q <= '0;
                    if (tx_start) begin
                        tx_state_q <= TxStart;
                        tx_div_q   <= div_q;
                        tx_byte_q  <= bus.wd[7:0];
                        uart_tx_q  <= 1'b0;
`ifdef UART_PARITY_EN
                        tx_par_en_q  <= par_en_q;
                        tx_par_odd_q <= par_odd_q;
`endif
                    end
                end
                TxStart: begin
                    if (tx_tick) begin
                        tx_state_q <= TxData;
                        tx_bit_q   <= '0;
                        uart_tx_q  <= tx_byte_q[0];
                    end
                end
                TxData: begin
                    if (tx_tick) begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            if (tx_par_en_q) begin
                                tx_state_q <= TxParity;
                                uart_tx_q  <= (^tx_byte_q) ^ tx_par_odd_q;
                            end else begin
                                tx_state_q <= TxStop;
                                uart_tx_q  <= 1'b1;
                            end
`else
                            tx_state_q <= TxStop;
                            uart_tx_q  <= 1'b1;
`endif
                        end else begin
                            uart_tx_q <= tx_byte_q[tx_bit_q + 3'd1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TxParity: begin
                    if (tx_tick) begin
                        tx_state_q <= TxStop;
                        uart_tx_q  <= 1'b1;
                    end
                end
`endif
                TxStop: begin
                    if (tx_tick) tx_state_q <= TxIdle;
                end
                default: begin
                    tx_state_q <= TxIdle;
                    uart_tx_q  <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read mux; undecoded offsets read zero.
    always_comb begin
        rd_data = '0;
        case (sel)
            OFF_RXDATA: rd_data[7:0] = rxdata_q;
            OFF_STATUS: begin
                rd_data[ST_TX_BUSY]    = tx_busy;
                rd_data[ST_RX_VALID]   = rx_valid_q;
                rd_data[ST_RX_OVERRUN] = rx_overrun_q;
                rd_data[ST_FRAME_ERR]  = frame_err_q;
`ifdef UART_PARITY_EN
                rd_data[ST_PAR_ERR]    = par_err_q;
`endif
            end
            OFF_DIV:    rd_data[15:0] = div_q;
            OFF_CTRL: begin
                rd_data[CT_TX_EN] = tx_en_q;
                rd_data[CT_RX_EN] = rx_en_q;
`ifdef UART_PARITY_EN
                rd_data[CT_PAR_EN]  = par_en_q;
                rd_data[CT_PAR_ODD] = par_odd_q;
`endif
            end
            default: rd_data = '0;
        endcase
    end

    assign bus.rd = rd_data;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized scoreboard bench for uart_core (pin monitor for TX, read monitor
// for registers). Optional feature macro: UART_PARITY_EN.
module tb_uart_core;

    logic clk = 1'b0;
    logic resetn;
    logic uart_tx;
    logic uart_rx;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    uart_if bus ();

    uart_core dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef UART_PARITY_EN
    localparam logic [31:0] CTRL_MASK = 32'hF;
    localparam bit          HAS_PAR   = 1'b1;
`else
    localparam logic [31:0] CTRL_MASK = 32'h3;
    localparam bit          HAS_PAR   = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        int         div;
        bit         par;
        bit         odd;
    } txe_t;

    txe_t        txq[$];
    logic [31:0] rexp_q[$];
    string       rname_q[$];
    logic        rd_req = 1'b0;
    bit          tx_mon_en = 1'b1;

    // Reference model of the programmer-visible state
    int          m_div;
    logic [31:0] m_ctrl;
    logic [7:0]  m_rxdata;
    bit          m_valid, m_ovr, m_ferr, m_perr;

    function automatic logic [31:0] exp_stat(input bit busy);
        return {27'd0, m_perr, m_ferr, m_ovr, m_valid, busy};
    endfunction

    task automatic model_reset();
        m_div = 868; m_ctrl = '0; m_rxdata = '0;
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) cyc1();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.we = 1'b1; bus.wd = d;
        cyc1();
        bus.we = 1'b0;
        case (a[4:2])
            3'd2: begin
                if (d[1]) m_valid = 0;
                if (d[2]) m_ovr = 0;
                if (d[3]) m_ferr = 0;
                if (d[4] && HAS_PAR) m_perr = 0;
            end
            3'd3: m_div = (d[15:0] < 16'd4) ? 4 : int'(d[15:0]);
            3'd4: m_ctrl = d & CTRL_MASK;
            default: ;
        endcase
    endtask

    // Queue an expected read value; the read monitor compares it this cycle.
    task automatic chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus.addr = a;
        rexp_q.push_back(exp);
        rname_q.push_back(nm);
        rd_req = 1'b1;
        cyc1();
        rd_req = 1'b0;
    endtask

    // Caller guarantees TX is idle and tx_en set, so the frame must appear on the pin.
    task automatic tx_send(input logic [7:0] b);
        txe_t e;
        e.b = b; e.div = m_div; e.par = m_ctrl[2]; e.odd = m_ctrl[3];
        txq.push_back(e);
        wr(32'h0, {24'hABCDEF, b});
    endtask

    task automatic drain();
        int k = 0;
        while (txq.size() != 0 && k < 20000) begin
            cyc1();
            k++;
        end
        repeat (200) cyc1();
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop, input bit pbit, input bit use_par);
        int d = m_div;
        uart_rx = 1'b0;
        repeat (d) cyc1();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (d) cyc1();
        end
        if (use_par) begin
            uart_rx = pbit;
            repeat (d) cyc1();
        end
        uart_rx = stop;
        repeat (d) cyc1();
        uart_rx = 1'b1;
        repeat (d + 6) cyc1();
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop, input bit bad_par);
        bit use_par = m_ctrl[2];
        bit pb = (^b) ^ m_ctrl[3] ^ bad_par;
        bit en = m_ctrl[1];
        send_rx(b, stop, pb, use_par);
        if (en) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_rxdata = b;
            if (!stop) m_ferr = 1;
            if (use_par && bad_par) m_perr = 1;
        end
    endtask

    // Read monitor: compares rd against the queued expectation on each requested read.
    initial begin : read_mon
        logic [31:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                e  = rexp_q.pop_front();
                nm = rname_q.pop_front();
                total++;
                if (bus.rd !== e) begin
                    bad++;
                    $display("FAIL %s: rd=%h expected=%h (t=%0t)", nm, bus.rd, e, $time);
                end
            end
        end
    end

    // TX pin monitor: each frame must match the expected bit list, each bit exactly div cycles.
    initial begin : tx_mon
        txe_t e;
        bit   bits[11];
        int   nb;
        bit   ok;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && tx_mon_en && uart_tx === 1'b0) begin
                if (txq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: frame start seen with nothing queued (t=%0t)",
                             $time);
                    while (uart_tx === 1'b0) @(negedge clk);
                end else begin
                    e = txq.pop_front();
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i + 1] = e.b[i];
                    nb = e.par ? 11 : 10;
                    if (e.par) bits[9] = (^e.b) ^ e.odd;
                    bits[nb - 1] = 1'b1;
                    for (int i = 0; i < nb; i++) begin
                        ok = 1;
                        for (int c = 0; c < e.div; c++) begin
                            if (!(i == 0 && c == 0)) @(negedge clk);
                            if (uart_tx !== bits[i]) ok = 0;
                        end
                        total++;
                        if (!ok) begin
                            bad++;
                            $display("FAIL tx_bit%0d byte=%h: pin differed from required %b",
                                     i, e.b, bits[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int          n, d;
        logic [7:0]  b;
        bus.addr = '0; bus.we = 1'b0; bus.wd = '0;
        uart_rx = 1'b1;
        resetn = 1'b0;
        model_reset();
        repeat (3) cyc1();
        resetn = 1'b1;
        cyc1();

        total++;
        if (uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL rst_tx: uart_tx=%b expected=1", uart_tx);
        end
        for (int i = 0; i < 8; i++) chk(i * 4, (i == 3) ? 32'd868 : 32'd0, "rst_reg");

        // Divisor clamp and CTRL implemented bits
        wr(32'hC, 32'd2);          chk(32'hC, 32'd4, "div_clamp2");
        wr(32'hFFFF_FFEC, 32'd0);  chk(32'hC, 32'd4, "div_clamp0_hi_addr");
        wr(32'hC, 32'hFFFF_0005);  chk(32'hC, 32'd5, "div_5");
        wr(32'h10, 32'hFF);        chk(32'h10, CTRL_MASK, "ctrl_mask");
        wr(32'h14, 32'hFFFF_FFFF); chk(32'h14, 32'd0, "unmapped");

        // 0xA5 at DIV=8: busy for exactly 80 cycles, write while busy ignored
        wr(32'hC, 32'd8);
        wr(32'h10, 32'h1);
        n = cyc;
        tx_send(8'hA5);
        chk(32'h8, 32'h1, "busy_first");
        wr(32'h0, 32'h5A);
        wait_until(n + 80);
        chk(32'h8, 32'h1, "busy_last");
        chk(32'h8, 32'h0, "busy_fall");
        drain();

        // Back-to-back frames at random divisors
        for (int it = 0; it < 3; it++) begin
            d = $urandom_range(4, 10);
            wr(32'hC, d);
            n = cyc;
            tx_send(8'($urandom));
            wait_until(n + 10 * d + 1);
            tx_send(8'($urandom));
            drain();
        end

        // DIV change mid-frame only affects the next frame
        wr(32'hC, 32'd6);
        tx_send(8'($urandom));
        repeat (15) cyc1();
        wr(32'hC, 32'd10);
        drain();
        tx_send(8'($urandom));
        drain();

        // Clearing tx_en mid-frame completes the frame; writes with tx_en=0 are ignored
        tx_send(8'($urandom));
        repeat (12) cyc1();
        wr(32'h10, 32'h0);
        drain();
        wr(32'h0, 32'h55);
        repeat (150) cyc1();
        chk(32'h8, 32'h0, "txen_off_idle");

        // Receive path at DIV=8
        wr(32'hC, 32'd8);
        wr(32'h10, 32'h2);
        rx_frame(8'h3C, 1, 0);
        chk(32'h4, 32'h3C, "rx_3c");
        chk(32'h8, 32'h2, "rx_3c_stat");
        wr(32'h8, 32'h2);
        chk(32'h8, 32'h0, "rx_w1c");
        rx_frame(8'h11, 1, 0);
        rx_frame(8'h22, 1, 0);
        chk(32'h4, 32'h22, "rx_ovr_data");
        chk(32'h8, 32'h6, "rx_ovr_stat");
        wr(32'h8, 32'hE);
        rx_frame(8'h5A, 0, 0);
        chk(32'h8, exp_stat(0), "rx_ferr_stat");
        wr(32'h8, 32'hE);

        // Short glitch is a false start; the next real frame still arrives
        uart_rx = 1'b0;
        cyc1();
        cyc1();
        uart_rx = 1'b1;
        repeat (30) cyc1();
        chk(32'h8, 32'h0, "glitch_stat");
        rx_frame(8'h81, 1, 0);
        chk(32'h4, 32'h81, "after_glitch");
        wr(32'h8, 32'hE);

        // rx_en cleared mid-frame: nothing stored
        fork
            send_rx(8'h99, 1, 0, 0);
            begin
                repeat (30) cyc1();
                wr(32'h10, 32'h0);
            end
        join
        wr(32'h10, 32'h2);
        chk(32'h8, 32'h0, "abort_stat");
        chk(32'h4, 32'h81, "abort_data");

        // Randomized receive with random W1C writes
        for (int it = 0; it < 6; it++) begin
            wr(32'hC, {16'($urandom), 16'($urandom_range(4, 12))});
            if ($urandom_range(0, 1) == 1) wr(32'h8, $urandom);
            b = 8'($urandom);
            rx_frame(b, $urandom_range(0, 3) != 0, 0);
            chk(32'h4, {24'd0, m_rxdata}, "rx_rand_data");
            chk(32'h8, exp_stat(0), "rx_rand_stat");
        end
        wr(32'h8, 32'h1E);

`ifdef UART_PARITY_EN
        wr(32'hC, 32'd8);
        wr(32'h10, 32'h5);
        tx_send(8'h07);
        drain();
        wr(32'h10, 32'hD);
        tx_send(8'($urandom));
        drain();
        wr(32'h10, 32'h6);
        rx_frame(8'h07, 1, 1);
        chk(32'h4, 32'h07, "par_data");
        chk(32'h8, 32'h12, "par_err");
        wr(32'h8, 32'h1E);
        rx_frame(8'($urandom), 1, 0);
        chk(32'h8, exp_stat(0), "par_ok");
        wr(32'h8, 32'h1E);
`endif

        // Reset mid-frame: uart_tx returns high at once and registers revert
        wr(32'hC, 32'd8);
        wr(32'h10, 32'h1);
        tx_mon_en = 1'b0;
        wr(32'h0, 32'h00);
        repeat (20) cyc1();
        resetn = 1'b0;
        model_reset();
        #2;
        total++;
        if (uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL rst_async_tx: uart_tx=%b expected=1", uart_tx);
        end
        chk(32'hC, 32'd868, "rst_mid_div");
        chk(32'h10, 32'd0, "rst_mid_ctrl");
        resetn = 1'b1;
        cyc1();
        tx_mon_en = 1'b1;
        chk(32'h8, 32'd0, "rst_mid_stat");

        drain();
        total++;
        if (txq.size() != 0) begin
            bad++;
            $display("FAIL tx_drain: %0d frames never seen, expected 0", txq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
